// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port round-robin arbiter and single-access sequencer for the data memory.
// Port 0 is the core load/store path, port 1 the debug/DMA requester. One
// request is accepted at a time. It is screened for funct3 legality,
// alignment and range. The block then runs one memory cycle and returns the
// result to the owning port through a valid/ready response.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid_x / req_ready_x  request handshake (x = 0, 1)
//   req_we_x, req_funct3_x     store flag, RISC-V load/store funct3
//   req_addr_x, req_wdata_x    byte address, right-aligned store data
//   rsp_valid_x / rsp_ready_x  response handshake
//   rsp_rdata_x, rsp_err_x     load result (0 on store/error), reject flag
//   mem_read, mem_write        memory strobes, asserted only in ACCESS
//   mem_funct3, mem_addr,      latched access attributes
//   mem_wdata
//   mem_rdata                  combinational, already extended read data
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic        req_we_0,
  input  logic [2:0]  req_funct3_0,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_wdata_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic        req_we_1,
  input  logic [2:0]  req_funct3_1,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_wdata_1,
  output logic        rsp_valid_0,
  input  logic        rsp_ready_0,
  output logic [31:0] rsp_rdata_0,
  output logic        rsp_err_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_rdata_1,
  output logic        rsp_err_1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        prio_q;    // port that wins when both request
  logic        owner_q;
  logic        we_q;
  logic        err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        grant_0, grant_1;
  logic        win_we;
  logic [2:0]  win_f3;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_err;
  logic [2:0]  size_m1;
  logic [32:0] last_byte;

  always_comb begin
    state_d = state_q;
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    case (state_q)
      IDLE: begin
        grant_0 = req_valid_0 & (~req_valid_1 | ~prio_q);
        grant_1 = req_valid_1 & (~req_valid_0 | prio_q);
        if (grant_0 | grant_1) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: if (owner_q ? rsp_ready_1 : rsp_ready_0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign win_we    = grant_1 ? req_we_1     : req_we_0;
  assign win_f3    = grant_1 ? req_funct3_1 : req_funct3_0;
  assign win_addr  = grant_1 ? req_addr_1   : req_addr_0;
  assign win_wdata = grant_1 ? req_wdata_1  : req_wdata_0;

  // Range is checked on the last touched byte in 33 bits so that addresses
  // near 2^32 cannot wrap back into the legal window.
  always_comb begin
    win_err = 1'b0;
    case (win_f3[1:0])
      2'b01:   size_m1 = 3'd1;
      2'b10:   size_m1 = 3'd3;
      default: size_m1 = 3'd0;
    endcase
    if (win_we) begin
      if (win_f3[2] || win_f3[1:0] == 2'b11) win_err = 1'b1;
    end else if (win_f3 == 3'b011 || win_f3[2:1] == 2'b11) begin
      win_err = 1'b1;
    end
    if (win_f3[1:0] == 2'b01 && win_addr[0]) win_err = 1'b1;
    if (win_f3[1:0] == 2'b10 && win_addr[1:0] != 2'b00) win_err = 1'b1;
    last_byte = {1'b0, win_addr} + {30'b0, size_m1};
    if (last_byte >= 33'(MEM_BYTES)) win_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_0 | grant_1) begin
        owner_q  <= grant_1;
        prio_q   <= ~grant_1;
        we_q     <= win_we;
        err_q    <= win_err;
        funct3_q <= win_f3;
        addr_q   <= win_addr;
        wdata_q  <= win_wdata;
      end
      if (state_q == ACCESS) rdata_q <= (!we_q && !err_q) ? mem_rdata : '0;
    end
  end

  // Strobes depend on state only, so a store in ACCESS still lands in memory
  // on an edge where reset is asserted.
  assign mem_read   = (state_q == ACCESS) & ~we_q & ~err_q;
  assign mem_write  = (state_q == ACCESS) &  we_q & ~err_q;
  assign mem_funct3 = funct3_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  assign rsp_valid_0 = (state_q == RESP) & ~owner_q;
  assign rsp_valid_1 = (state_q == RESP) &  owner_q;
  assign rsp_rdata_0 = rsp_valid_0 ? rdata_q : '0;
  assign rsp_rdata_1 = rsp_valid_1 ? rdata_q : '0;
  assign rsp_err_0   = rsp_valid_0 & err_q;
  assign rsp_err_1   = rsp_valid_1 & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of single transactions plus
// hand-written round-robin, backpressure and reset sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_0, req_ready_0, req_we_0;
  logic [2:0]  req_funct3_0;
  logic [31:0] req_addr_0, req_wdata_0;
  logic        req_valid_1, req_ready_1, req_we_1;
  logic [2:0]  req_funct3_1;
  logic [31:0] req_addr_1, req_wdata_1;
  logic        rsp_valid_0, rsp_ready_0, rsp_err_0;
  logic [31:0] rsp_rdata_0;
  logic        rsp_valid_1, rsp_ready_1, rsp_err_1;
  logic [31:0] rsp_rdata_1;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
    .req_funct3_0(req_funct3_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
    .req_funct3_1(req_funct3_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_rdata_0(rsp_rdata_0),
    .rsp_err_0(rsp_err_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_rdata_1(rsp_rdata_1),
    .rsp_err_1(rsp_err_1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte-addressed little-endian data memory model.
  logic [7:0] mem [0:127];

  initial for (int i = 0; i < 128; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if ((b == 0 || (b == 1 && mem_funct3[1:0] != 2'b00) || mem_funct3[1:0] == 2'b10)
            && (mem_addr + 32'(b) < 32'd128))
          mem[7'(mem_addr + 32'(b))] <= mem_wdata[8*b +: 8];
      end
    end
  end

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return (a < 32'd128) ? mem[a[6:0]] : 8'h00;
  endfunction

  always_comb begin
    mem_rdata = '0;
    case (mem_funct3)
      3'b000: mem_rdata = {{24{rd_byte(mem_addr)[7]}}, rd_byte(mem_addr)};
      3'b100: mem_rdata = {24'h0, rd_byte(mem_addr)};
      3'b001: mem_rdata = {{16{rd_byte(mem_addr + 1)[7]}}, rd_byte(mem_addr + 1), rd_byte(mem_addr)};
      3'b101: mem_rdata = {16'h0, rd_byte(mem_addr + 1), rd_byte(mem_addr)};
      3'b010: mem_rdata = {rd_byte(mem_addr + 3), rd_byte(mem_addr + 2),
                           rd_byte(mem_addr + 1), rd_byte(mem_addr)};
      default: mem_rdata = '0;
    endcase
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input bit port, input bit v, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      req_valid_1 = v; req_we_1 = we; req_funct3_1 = f3; req_addr_1 = addr; req_wdata_1 = wdata;
    end else begin
      req_valid_0 = v; req_we_0 = we; req_funct3_0 = f3; req_addr_0 = addr; req_wdata_0 = wdata;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned n;
    logic [1:0] rdy_exp, strobe_exp;
    n = 0;
    rdy_exp = v.port ? 2'b10 : 2'b01;
    strobe_exp = v.exp_err ? 2'b00 : (v.we ? 2'b01 : 2'b10);
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.f3, v.addr, v.wdata);
    #1;
    while ((v.port ? req_ready_1 : req_ready_0) !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", {30'b0, req_ready_1, req_ready_0}, {30'b0, rdy_exp});
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("access_strobes", {30'b0, mem_read, mem_write}, {30'b0, strobe_exp});
    chk("access_addr", mem_addr, v.addr);
    chk("access_no_rsp", {30'b0, rsp_valid_1, rsp_valid_0}, 32'h0);
    @(negedge clk);
    chk("rsp_valid", {30'b0, rsp_valid_1, rsp_valid_0}, {30'b0, rdy_exp});
    chk("rsp_rdata", v.port ? rsp_rdata_1 : rsp_rdata_0, v.exp_rdata);
    chk("rsp_err", {31'b0, v.port ? rsp_err_1 : rsp_err_0}, {31'b0, v.exp_err});
    chk("resp_no_strobe", {30'b0, mem_read, mem_write}, 32'h0);
    if (v.port) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    //        port we  f3      addr          wdata         exp_rdata     err
    vecs[0]  = '{0, 1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        0};
    vecs[1]  = '{0, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{1, 1, 3'b000, 32'h12,       32'h00000080, 32'h0,        0};
    vecs[3]  = '{1, 0, 3'b000, 32'h12,       32'h0,        32'hFFFFFF80, 0};
    vecs[4]  = '{1, 0, 3'b100, 32'h12,       32'h0,        32'h00000080, 0};
    vecs[5]  = '{0, 0, 3'b010, 32'h11,       32'h0,        32'h0,        1};
    vecs[6]  = '{0, 0, 3'b001, 32'h13,       32'h0,        32'h0,        1};
    vecs[7]  = '{1, 1, 3'b010, 32'h80,       32'h11111111, 32'h0,        1};
    vecs[8]  = '{0, 1, 3'b100, 32'h10,       32'h22222222, 32'h0,        1};
    vecs[9]  = '{0, 0, 3'b010, 32'h10,       32'h0,        32'hDE80BEEF, 0};
    vecs[10] = '{1, 1, 3'b001, 32'h7E,       32'h1234ABCD, 32'h0,        0};
    vecs[11] = '{1, 0, 3'b001, 32'h7E,       32'h0,        32'hFFFFABCD, 0};
    vecs[12] = '{0, 0, 3'b101, 32'h7E,       32'h0,        32'h0000ABCD, 0};
    vecs[13] = '{0, 0, 3'b010, 32'h7C,       32'h0,        32'hABCD0000, 0};
    vecs[14] = '{1, 0, 3'b000, 32'h7F,       32'h0,        32'hFFFFFFAB, 0};
    vecs[15] = '{0, 0, 3'b011, 32'h00,       32'h0,        32'h0,        1};
    vecs[16] = '{1, 0, 3'b010, 32'h7D,       32'h0,        32'h0,        1};
    vecs[17] = '{0, 0, 3'b000, 32'h80,       32'h0,        32'h0,        1};
    vecs[18] = '{1, 0, 3'b100, 32'hFFFFFFFF, 32'h0,        32'h0,        1};
    vecs[19] = '{1, 1, 3'b011, 32'h00,       32'h33333333, 32'h0,        1};
    vecs[20] = '{0, 0, 3'b110, 32'h00,       32'h0,        32'h0,        1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {24'b0, req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0,
                       rsp_err_1, rsp_err_0, mem_read, mem_write}, 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    chk("reset_funct3", {29'b0, mem_funct3}, 32'h0);
    chk("reset_rdata", rsp_rdata_0 | rsp_rdata_1, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) run_vec(vecs[i]);

    // Both ports requesting back-to-back: strict alternation from port 0.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h7C, 32'h0);
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", {30'b0, req_ready_1, req_ready_0}, (i % 2) ? 32'h2 : 32'h1);
      @(negedge clk);
      chk("rr_access_read", {31'b0, mem_read}, 32'h1);
      @(negedge clk);
      chk("rr_rsp_owner", {30'b0, rsp_valid_1, rsp_valid_0}, (i % 2) ? 32'h2 : 32'h1);
      chk("rr_rdata", (i % 2) ? rsp_rdata_1 : rsp_rdata_0, (i % 2) ? 32'hABCD0000 : 32'hDE80BEEF);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;

    // Response backpressure on port 0 blocks port 1 until released.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h7C, 32'h0);
    #1;
    chk("bp_grant0", {30'b0, req_ready_1, req_ready_0}, 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("bp_access_ready", {30'b0, req_ready_1, req_ready_0}, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", {31'b0, rsp_valid_0}, 32'h1);
      chk("bp_hold_rdata", rsp_rdata_0, 32'hDE80BEEF);
      chk("bp_ready1_low", {31'b0, req_ready_1}, 32'h0);
      @(negedge clk);
    end
    rsp_ready_0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready_0 = 1'b0;
    @(negedge clk);
    chk("bp_grant1_after", {30'b0, req_ready_1, req_ready_0}, 32'h2);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp1", {30'b0, rsp_valid_1, rsp_valid_0}, 32'h2);
    chk("bp_rdata1", rsp_rdata_1, 32'hABCD0000);
    rsp_ready_1 = 1'b1;
    @(posedge clk); #1;
    rsp_ready_1 = 1'b0;

    // Reset during RESP drops the response and restores port-0 priority.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_valid", {31'b0, rsp_valid_0}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_drop_rsp", {28'b0, rsp_valid_1, rsp_valid_0, mem_read, mem_write}, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h7C, 32'h0);
    #1;
    chk("rst_prio_port0", {30'b0, req_ready_1, req_ready_0}, 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_after_rdata", rsp_rdata_0, 32'hDE80BEEF);
    rsp_ready_0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready_0 = 1'b0;

    // Store whose ACCESS cycle meets the reset edge still reaches memory.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_store_strobe", {31'b0, mem_write}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec('{1, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
